// File: rtl/riscv_muldiv_unit.sv
// riscv_muldiv_unit
//   Iterative RV32M multiply/divide unit. Takes rs1/rs2 values from the
//   register file, works one bit per cycle, and writes the result back
//   through a one-cycle register-file write port. The latency is fixed at
//   XLEN+2 cycles for every operation, including the special cases.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   start_i              request; taken only while idle
//   op_i                 funct3 (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU)
//   a_i, b_i             rs1 / rs2 operand values
//   rd_addr_i            destination register
//   flush_i              kills the in-flight operation
//   busy_o               high whenever an operation is in flight
//   done_o               one-cycle completion pulse
//   wb_we_o/addr_o/data_o  register-file write-back
module riscv_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            wb_we_o,
  output logic [4:0]      wb_addr_o,
  output logic [XLEN-1:0] wb_data_o
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   a_mag_q, b_mag_q, dvd_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CW-1:0]     cnt_q;
  logic              neg_q, dz_q, ovf_q;
  logic [XLEN-1:0]   wb_data_q;
  logic [4:0]        wb_addr_q;

  logic              last_iter;
  assign last_iter = (cnt_q == CW'(XLEN));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = CALC;
      CALC:    if (flush_i) state_d = IDLE;
               else if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (state_q != IDLE);
    done_o  = (state_q == DONE);
    wb_we_o = (state_q == DONE) && (rd_q != 5'd0);
  end

  // ------------------------------------------------ operand preparation
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            neg_in, dz_in, ovf_in;

  always_comb begin
    // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM
    a_sgn  = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
    b_sgn  = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
    a_neg  = a_sgn && a_i[XLEN-1];
    b_neg  = b_sgn && b_i[XLEN-1];
    a_mag  = a_neg ? -a_i : a_i;
    b_mag  = b_neg ? -b_i : b_i;
    // Remainder follows the dividend sign; everything else follows the XOR.
    neg_in = (op_i == 3'b110) ? a_neg : (a_neg ^ b_neg);
    dz_in  = op_i[2] && (b_i == '0);
    ovf_in = ((op_i == 3'b100) || (op_i == 3'b110)) &&
             (a_i == SMIN) && (b_i == {XLEN{1'b1}});
  end

  // ------------------------------------------------------- iteration step
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN:0]     div_sh;
  logic [XLEN+1:0]   div_diff;
  logic              div_ok;
  logic [2*XLEN-1:0] div_nxt;

  always_comb begin
    // Multiply: acc = {partial, multiplier}; add on LSB, then shift right.
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_mag_q} : '0);
    mul_nxt  = {mul_sum, acc_q[XLEN-1:1]};
    // Divide: acc = {remainder, dividend/quotient}; shift left, trial-subtract.
    div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = {1'b0, div_sh} - {2'b00, b_mag_q};
    div_ok   = ~div_diff[XLEN+1];
    div_nxt  = {(div_ok ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]),
                acc_q[XLEN-2:0], div_ok};
  end

  // --------------------------------------------------------- final result
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, res;

  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    quo  = acc_q[XLEN-1:0];
    rem  = acc_q[2*XLEN-1:XLEN];
    res  = '0;
    if (!op_q[2])
      res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (dz_q)
      res = op_q[1] ? dvd_q : {XLEN{1'b1}};
    else if (ovf_q)
      res = op_q[1] ? '0 : SMIN;
    else if (op_q[1])
      res = neg_q ? -rem : rem;
    else
      res = neg_q ? -quo : quo;
  end

  // ------------------------------------------------------------- datapath
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q      <= '0;
      rd_q      <= '0;
      a_mag_q   <= '0;
      b_mag_q   <= '0;
      dvd_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      wb_data_q <= '0;
      wb_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          op_q    <= op_i;
          rd_q    <= rd_addr_i;
          a_mag_q <= a_mag;
          b_mag_q <= b_mag;
          dvd_q   <= a_i;
          // Multiplier or dividend goes into the low half of the accumulator.
          acc_q   <= {{XLEN{1'b0}}, (op_i[2] ? a_mag : b_mag)};
          cnt_q   <= '0;
          neg_q   <= neg_in;
          dz_q    <= dz_in;
          ovf_q   <= ovf_in;
        end
        CALC: if (!flush_i) begin
          if (!last_iter) begin
            acc_q <= op_q[2] ? div_nxt : mul_nxt;
            cnt_q <= cnt_q + CW'(1);
          end else begin
            wb_data_q <= res;
            wb_addr_q <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign wb_data_o = wb_data_q;
  assign wb_addr_o = wb_addr_q;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Directed bench for riscv_muldiv_unit: fixed latency, sign rules, special
// cases, start handshake, flush and mid-operation reset.
module tb_riscv_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        busy_o, done_o, wb_we_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;

  int n_tests = 0;
  int n_fail  = 0;

  riscv_muldiv_unit #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .rd_addr_i(rd_addr_i), .flush_i(flush_i),
    .busy_o(busy_o), .done_o(done_o), .wb_we_o(wb_we_o),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge with the unit idle. Ends #1 after the edge that
  // returns it to idle.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp);
    int early;
    int bcnt;
    start_i = 1'b1; op_i = op; a_i = a; b_i = b; rd_addr_i = rd;
    @(posedge clk_i); #1;                    // accept edge N
    start_i = 1'b0;
    op_i = 3'($urandom); a_i = $urandom; b_i = $urandom; rd_addr_i = 5'($urandom);
    early = 0;
    bcnt  = busy_o ? 1 : 0;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk_i); #1;
      if (done_o) early++;
      if (busy_o) bcnt++;
    end
    @(posedge clk_i); #1;                    // edge N+33: DONE cycle
    if (busy_o) bcnt++;
    chk({tag, " done"}, 32'(done_o), 32'd1);
    chk({tag, " data"}, wb_data_o, exp);
    chk({tag, " addr"}, 32'(wb_addr_o), 32'(rd));
    chk({tag, " we"},   32'(wb_we_o), 32'(rd != 5'd0));
    @(posedge clk_i); #1;                    // edge N+34: back to IDLE
    chk({tag, " early_done"}, 32'(early), 32'd0);
    chk({tag, " busy_cycles"}, 32'(bcnt), 32'd34);
    chk({tag, " done_low"}, 32'(done_o), 32'd0);
    chk({tag, " idle"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    int acc_n;
    int second;
    int t;
    logic prev;

    rst_i = 1'b1; start_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    rd_addr_i = '0; flush_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst busy", 32'(busy_o), 32'd0);
    chk("rst done", 32'(done_o), 32'd0);
    chk("rst we",   32'(wb_we_o), 32'd0);
    chk("rst addr", 32'(wb_addr_o), 32'd0);
    chk("rst data", wb_data_o, 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Multiply
    run_op("mul",    3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB);
    run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF);
    // Divide
    run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,   5'd10, 32'hFFFF_FFFD);
    run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,   5'd11, 32'hFFFF_FFFF);
    run_op("divu",   3'b101, 32'd100,       32'd7,   5'd12, 32'd14);
    run_op("remu",   3'b111, 32'd100,       32'd7,   5'd13, 32'd2);
    // Special cases
    run_op("div0",   3'b100, 32'd5,         32'd0,   5'd14, 32'hFFFF_FFFF);
    run_op("rem0",   3'b110, 32'd5,         32'd0,   5'd15, 32'd5);
    run_op("divu0",  3'b101, 32'h8000_0000, 32'd0,   5'd16, 32'hFFFF_FFFF);
    run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000);
    run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0);
    // rd = 0: completes, no write
    run_op("rd0",    3'b000, 32'd2, 32'd3, 5'd0, 32'd6);

    // start held high for 40 cycles: accepts at cycle 0 and cycle 35
    start_i = 1'b1; op_i = 3'b000; a_i = 32'd3; b_i = 32'd4; rd_addr_i = 5'd9;
    acc_n = 0; second = -1; prev = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk_i); #1;
      if (busy_o && !prev) begin
        acc_n++;
        if (acc_n == 2) second = c;
      end
      prev = busy_o;
    end
    start_i = 1'b0;
    chk("held accepts", 32'(acc_n), 32'd2);
    chk("held second_at", 32'(second), 32'd35);
    t = 0;
    while (busy_o && t < 100) begin
      @(posedge clk_i); #1;
      t++;
    end
    chk("held drain", 32'(busy_o), 32'd0);
    chk("held result", wb_data_o, 32'd12);

    // Flush in CALC cycle 10, with a competing start in the same cycle
    run_op("pre_flush", 3'b111, 32'd100, 32'd7, 5'd4, 32'd2);
    start_i = 1'b1; op_i = 3'b100; a_i = 32'd5; b_i = 32'd0; rd_addr_i = 5'd7;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1;
    flush_i = 1'b1; start_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0; start_i = 1'b0;
    chk("flush busy", 32'(busy_o), 32'd0);
    chk("flush done", 32'(done_o), 32'd0);
    chk("flush we",   32'(wb_we_o), 32'd0);
    chk("flush data", wb_data_o, 32'd2);
    run_op("post_flush", 3'b101, 32'd100, 32'd7, 5'd3, 32'd14);

    // Reset in CALC cycle 20
    start_i = 1'b1; op_i = 3'b000; a_i = 32'd9; b_i = 32'd9; rd_addr_i = 5'd20;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (19) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("midrst busy", 32'(busy_o), 32'd0);
    chk("midrst done", 32'(done_o), 32'd0);
    chk("midrst we",   32'(wb_we_o), 32'd0);
    chk("midrst addr", 32'(wb_addr_o), 32'd0);
    chk("midrst data", wb_data_o, 32'd0);
    repeat (40) @(posedge clk_i);
    #1;
    chk("midrst stays_idle", 32'(busy_o), 32'd0);
    chk("midrst no_late_data", wb_data_o, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_muldiv_unit.md
Name: riscv_muldiv_unit

Overview:
Iterative RV32M multiply/divide unit that sits between the register-file read ports and the register-file write port.
- Consumes rs1/rs2 operand values read from rf_riscv.
- Computes one M-extension operation over a fixed multi-cycle latency.
- Drives a one-cycle write-back (enable, address, data) that connects directly to rf_riscv's write port.
- Exposes busy_o so the core can stall issue while an operation is in flight.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported. Latency is XLEN+2 cycles.

Ports:
- clk_i  in  1  clock, all state updates on posedge
- rst_i  in  1  synchronous reset, active-high
- start_i  in  1  request; accepted only when state==IDLE
- op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a_i  in  XLEN  rs1 value (multiplicand/dividend)
- b_i  in  XLEN  rs2 value (multiplier/divisor)
- rd_addr_i  in  5  destination register
- flush_i  in  1  synchronous kill of the in-flight operation
- busy_o  out  1  high whenever state!=IDLE
- done_o  out  1  one-cycle completion pulse
- wb_we_o  out  1  register-file write enable
- wb_addr_o  out  5  register-file write address
- wb_data_o  out  XLEN  result

Behaviour:
- Interface: one clock (clk_i); reset is synchronous and active-high (rst_i).
- Reset values: state=IDLE; busy_o=0, done_o=0, wb_we_o=0, wb_addr_o=0, wb_data_o=0; counter and datapath registers=0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - At an edge with start_i=1: latch op_i and rd_addr_i.
  - Latch operand magnitudes: the absolute value for signed-interpreted operands, raw otherwise.
  - Latch the result-negate flag and the special-case flags (divide by zero; signed overflow 0x80000000 / 0xFFFFFFFF).
  - Clear the counter and go to CALC.
- CALC: exactly XLEN iterations, one per edge. After the XLEN-th iteration, go to DONE.
  - Multiply: shift-add over a 2*XLEN accumulator.
  - Divide: restoring divide (shift the remainder left, trial-subtract the divisor, set the quotient bit).
- Entry to DONE (same edge):
  - wb_data_o is loaded with the final result and holds until the next entry to DONE or reset.
  - wb_addr_o is loaded with the latched rd.
- DONE:
  - done_o=1 for this single cycle.
  - wb_we_o=1 for this single cycle, only if latched rd!=0.
  - The next edge returns to IDLE.
- Latency: start accepted at edge N, DONE occupies the cycle between edges N+XLEN+1 and N+XLEN+2 (N+33..N+34 for XLEN=32). Fixed for every op, including special cases.
- Throughput: one op per XLEN+2 cycles. start_i is ignored in CALC and DONE; it is not queued.
- Sign rules:
  - MUL: low XLEN bits of the product.
  - MULH: signed x signed, high half.
  - MULHSU: signed rs1 x unsigned rs2, high half.
  - MULHU: unsigned x unsigned, high half.
  - Product is negated (2*XLEN-bit two's complement) when exactly one signed-interpreted operand is negative.
  - DIV: quotient negated if operand signs differ. REM: remainder takes the dividend's sign.
- Special cases override the datapath result:
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the original dividend a_i.
  - Signed overflow: DIV gives 0x80000000; REM gives 0.
- flush_i:
  - At an edge with flush_i=1 in CALC or DONE: go to IDLE. done_o and wb_we_o are 0 from the next cycle; wb_data_o is unchanged.
  - flush_i outranks start_i in the same cycle: the start is dropped.
  - flush_i in IDLE has no effect.
- rst_i mid-operation: same as flush_i, but all outputs are also cleared; rst_i has highest priority.
- The op_i, a_i, b_i and rd_addr_i inputs may change freely after acceptance; only latched copies are used.

Test Plan:
- MUL 0x00000007 x 0xFFFFFFFD, rd=5 -> done_o pulse exactly 34 cycles after the accept edge; wb_we_o=1, wb_addr_o=5, wb_data_o=0xFFFFFFEB; busy_o high for 34 cycles.
- High halves:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Divide signs:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
  - REM 0xFFFFFFF9 % 2 -> 0xFFFFFFFF.
  - DIVU 100 / 7 -> 14.
  - REMU 100 % 7 -> 2.
- Special cases:
  - DIV 5 / 0 -> 0xFFFFFFFF; REM 5 % 0 -> 5.
  - DIVU 0x80000000 / 0 -> 0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
  - All still at 34-cycle latency.
- Handshake:
  - start_i held high for 40 cycles -> exactly two accepts, the second on the first IDLE cycle after DONE.
  - rd=0 op -> done_o pulses, wb_we_o stays 0.
- Kill:
  - flush_i in CALC cycle 10 -> IDLE next cycle, no done_o/wb_we_o, wb_data_o unchanged; new start accepted the following cycle completes normally.
  - rst_i in CALC cycle 20 -> all outputs 0, busy_o=0.
